mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Sequences all accesses to the single-port memory and shares it between instruction fetch and the data-access path; the data path supplies the address and store data produced by the execute-stage output generator (ALU result as address, rt contents as write data). Accepts at most one transaction at a time, issues it to memory for one cycle, waits a fixed memory latency, and returns a one-cycle valid pulse with read data to the winning requester. Data requests have priority, with a starvation limit guaranteeing fetch progress.

## Interface
- MEM_LAT, 1, memory read latency in cycles (legal 1..15): mem_rdata is valid MEM_LAT cycles after the mem_en cycle
- STARVE_MAX, 4, max consecutive data grants while inst_req is pending before a fetch grant is forced (legal 1..15)

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request; held high with stable inst_addr until inst_valid
- inst_addr  in  32  fetch byte address
- inst_valid  out  1  one-cycle completion pulse for fetch
- inst_rdata  out  32  fetched word, valid when inst_valid
- data_req  in  1  data request; held high with stable addr/wr/be/wdata until data_valid
- data_wr  in  1  1 = store, 0 = load
- data_be  in  4  store byte enables (ignored for loads)
- data_addr  in  32  byte address (ALU result)
- data_wdata  in  32  store data (rt contents)
- data_valid  out  1  one-cycle completion pulse for data access (loads and stores)
- data_rdata  out  32  loaded word, valid when data_valid
- mem_en  out  1  memory access strobe
- mem_wen  out  4  memory byte write enables
- mem_addr  out  32  word-aligned memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if no request, stay. Otherwise grant and latch the winner's addr/wr/be/wdata and an owner flag; next state ISSUE.
- Arbitration in IDLE: only one requester -> grant it. Both -> grant data unless starve_cnt == STARVE_MAX, then grant inst.
- starve_cnt (4 bits): increments on each data grant made while inst_req is high; clears on any inst grant, or on a data grant with inst_req low; saturates at STARVE_MAX.
- ISSUE (exactly 1 cycle): mem_en=1, mem_addr={latched_addr[31:2],2'b00}, mem_wen=latched_be if owner=data and wr=1 else 4'b0000, mem_wdata=latched wdata (0 for fetch). Load counter with MEM_LAT; next WAIT.
- WAIT: decrement counter each cycle; in the cycle where counter reaches 1, sample mem_rdata into the owner's rdata register (stores sample too; data_rdata content is don't-care for stores); next RESP.
- RESP (1 cycle): assert inst_valid or data_valid per owner; next IDLE unconditionally. Requests present in RESP are not arbitrated (requester may still hold req this cycle).
- mem_en=0, mem_wen=0 in all states except ISSUE; mem_addr/mem_wdata hold latched values outside ISSUE.
- Store with data_be=0000: still issued (mem_en=1, mem_wen=0), completes with data_valid.
- Address bits [1:0] are dropped; no misalignment detection.
- Request dropped before its valid: ignored; transaction completes and valid still pulses.

## Timing
- Reset: state IDLE, starve_cnt=0, counter=0, inst_valid=data_valid=0, mem_en=0, mem_wen=0, mem_addr=0, mem_wdata=0, inst_rdata=data_rdata=0.
- Reset mid-transaction: in-flight access abandoned, no valid pulse, outputs as above the next cycle.
- Request seen in IDLE at cycle 0 -> mem_en in cycle 1 -> valid in cycle MEM_LAT+2.
- Transaction period MEM_LAT+3 cycles; earliest next mem_en is MEM_LAT+3 cycles after previous.
- rdata registers hold until overwritten by the next transaction for the same owner.
- inst_valid and data_valid never high together; mem_en never high two consecutive cycles.

## Test plan
- Reset, MEM_LAT=1: load data_addr=0x0000_0013 at cycle 0 -> mem_en=1, mem_addr=0x0000_0010, mem_wen=0 at cycle 1; memory returns 0xDEAD_BEEF at cycle 2 -> data_valid=1, data_rdata=0xDEAD_BEEF at cycle 3.
- Store addr 0x20, wdata 0x1234_5678, be=0011 -> ISSUE cycle shows mem_wen=0011, mem_wdata=0x1234_5678; data_valid pulses once 2 cycles later; inst_valid stays 0.
- inst_req and data_req both held continuously, STARVE_MAX=4 -> grant order data,data,data,data,inst,repeat; each grant separated by MEM_LAT+3 cycles.
- MEM_LAT=3, fetch of 0x400 -> inst_valid exactly 5 cycles after request, inst_rdata equals mem_rdata sampled 3 cycles after mem_en.
- Assert rst during WAIT of a load -> no data_valid, all outputs 0 next cycle; subsequent request completes with normal latency.
- Store with be=0000 -> mem_en=1, mem_wen=0000, data_valid pulses; memory contents unchanged.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory sequencer shared by instruction fetch and the data path.
// One transaction in flight: IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> RESP.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_valid,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_be,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        mem_en,
    output logic [3:0]  mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [3:0] LAT        = 4'(MEM_LAT);

    state_t      state_q;
    logic        owner_data_q;
    logic [3:0]  starve_q;
    logic [3:0]  starve_d;
    logic [3:0]  cnt_q;
    logic        inst_valid_q;
    logic        data_valid_q;
    logic [31:0] inst_rdata_q;
    logic [31:0] data_rdata_q;
    logic        mem_en_q;
    logic [3:0]  mem_wen_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        grant_inst;
    logic        grant_data;

    function automatic logic [3:0] starve_inc(input logic [3:0] c);
        return (c >= STARVE_LIM) ? STARVE_LIM : c + 4'd1;
    endfunction

    // Data wins ties unless fetch has been passed over STARVE_MAX times in a row.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == IDLE) begin
            if (data_req && !(inst_req && starve_q == STARVE_LIM)) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (grant_inst) begin
            starve_d = 4'd0;
        end else if (grant_data) begin
            starve_d = inst_req ? starve_inc(starve_q) : 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_data_q <= 1'b0;
            starve_q     <= 4'd0;
            cnt_q        <= 4'd0;
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            inst_rdata_q <= 32'd0;
            data_rdata_q <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 4'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            inst_valid_q <= 1'b0;
            data_valid_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 4'd0;
            starve_q     <= starve_d;
            case (state_q)
                IDLE: begin
                    if (grant_inst || grant_data) begin
                        owner_data_q <= grant_data;
                        mem_en_q     <= 1'b1;
                        mem_addr_q   <= grant_data ? {data_addr[31:2], 2'b00}
                                                   : {inst_addr[31:2], 2'b00};
                        mem_wen_q    <= (grant_data && data_wr) ? data_be : 4'd0;
                        mem_wdata_q  <= grant_data ? data_wdata : 32'd0;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_q   <= LAT;
                    state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        if (owner_data_q) begin
                            data_rdata_q <= mem_rdata;
                        end else begin
                            inst_rdata_q <= mem_rdata;
                        end
                        data_valid_q <= owner_data_q;
                        inst_valid_q <= !owner_data_q;
                        state_q      <= RESP;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign inst_valid = inst_valid_q;
    assign inst_rdata = inst_rdata_q;
    assign data_valid = data_valid_q;
    assign data_rdata = data_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    a_valid_excl: assert property (@(posedge clk) disable iff (rst)
        !(inst_valid_q && data_valid_q));
    a_en_single: assert property (@(posedge clk) disable iff (rst)
        mem_en_q |=> !mem_en_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with its own latency-exact memory model.
module tb_mem_port_arbiter;

    localparam int L1 = 1;
    localparam int L3 = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    logic        a_inst_req, a_inst_valid, a_data_req, a_data_wr, a_data_valid, a_mem_en;
    logic [31:0] a_inst_addr, a_inst_rdata, a_data_addr, a_data_wdata, a_data_rdata;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_data_be, a_mem_wen;
    logic        b_inst_req, b_inst_valid, b_data_req, b_data_wr, b_data_valid, b_mem_en;
    logic [31:0] b_inst_addr, b_inst_rdata, b_data_addr, b_data_wdata, b_data_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_data_be, b_mem_wen;

    mem_port_arbiter #(.MEM_LAT(L1), .STARVE_MAX(4)) dut_a (
        .clk(clk), .rst(rst),
        .inst_req(a_inst_req), .inst_addr(a_inst_addr),
        .inst_valid(a_inst_valid), .inst_rdata(a_inst_rdata),
        .data_req(a_data_req), .data_wr(a_data_wr), .data_be(a_data_be),
        .data_addr(a_data_addr), .data_wdata(a_data_wdata),
        .data_valid(a_data_valid), .data_rdata(a_data_rdata),
        .mem_en(a_mem_en), .mem_wen(a_mem_wen), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_port_arbiter #(.MEM_LAT(L3), .STARVE_MAX(4)) dut_b (
        .clk(clk), .rst(rst),
        .inst_req(b_inst_req), .inst_addr(b_inst_addr),
        .inst_valid(b_inst_valid), .inst_rdata(b_inst_rdata),
        .data_req(b_data_req), .data_wr(b_data_wr), .data_be(b_data_be),
        .data_addr(b_data_addr), .data_wdata(b_data_wdata),
        .data_valid(b_data_valid), .data_rdata(b_data_rdata),
        .mem_en(b_mem_en), .mem_wen(b_mem_wen), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // Memory models: read data is only valid in the cycle exactly MEM_LAT after mem_en.
    logic [31:0] mem_a [0:1023];
    logic [31:0] mem_b [0:1023];
    logic [31:0] rd_a, rd_b;
    int          cd_a = 0;
    int          cd_b = 0;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem_a[i] <= 32'hC0DE_0000 | 32'(i);
            mem_a[4] <= 32'hDEAD_BEEF;
            cd_a <= 0;
        end else begin
            if (cd_a > 0) cd_a <= cd_a - 1;
            if (a_mem_en) begin
                rd_a <= mem_a[a_mem_addr[11:2]];
                cd_a <= L1;
                for (int k = 0; k < 4; k++)
                    if (a_mem_wen[k]) mem_a[a_mem_addr[11:2]][8*k +: 8] <= a_mem_wdata[8*k +: 8];
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) mem_b[i] <= 32'hB0B0_0000 | 32'(i);
            cd_b <= 0;
        end else begin
            if (cd_b > 0) cd_b <= cd_b - 1;
            if (b_mem_en) begin
                rd_b <= mem_b[b_mem_addr[11:2]];
                cd_b <= L3;
                for (int k = 0; k < 4; k++)
                    if (b_mem_wen[k]) mem_b[b_mem_addr[11:2]][8*k +: 8] <= b_mem_wdata[8*k +: 8];
            end
        end
    end

    assign a_mem_rdata = (cd_a == 1) ? rd_a : 32'hBAD0_BAD0;
    assign b_mem_rdata = (cd_b == 1) ? rd_b : 32'hBAD1_BAD1;

    typedef struct packed { logic [31:0] addr; logic [3:0] wen; logic [31:0] wdata; } iss_t;
    typedef struct packed { logic owner; logic [31:0] rdata; logic chk_rd; } rsp_t;

    iss_t iss_a[$];
    iss_t iss_b[$];
    rsp_t rsp_a[$];
    rsp_t rsp_b[$];
    iss_t ea, eb;
    rsp_t ra, rb;
    int   last_a = -100;
    int   last_b = -100;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_mem_en) begin
                last_a = cyc;
                if (iss_a.size() == 0) check("a_iss_unexp", 1, 0);
                else begin
                    ea = iss_a.pop_front();
                    check("a_mem_addr", a_mem_addr, ea.addr);
                    check("a_mem_wen", a_mem_wen, ea.wen);
                    check("a_mem_wdata", a_mem_wdata, ea.wdata);
                end
            end
            if (a_inst_valid || a_data_valid) begin
                check("a_valid_excl", a_inst_valid && a_data_valid, 0);
                if (rsp_a.size() == 0) check("a_rsp_unexp", 1, 0);
                else begin
                    ra = rsp_a.pop_front();
                    check("a_owner", a_data_valid, ra.owner);
                    if (ra.chk_rd) check("a_rdata", ra.owner ? a_data_rdata : a_inst_rdata, ra.rdata);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (b_mem_en) begin
                last_b = cyc;
                if (iss_b.size() == 0) check("b_iss_unexp", 1, 0);
                else begin
                    eb = iss_b.pop_front();
                    check("b_mem_addr", b_mem_addr, eb.addr);
                    check("b_mem_wen", b_mem_wen, eb.wen);
                    check("b_mem_wdata", b_mem_wdata, eb.wdata);
                end
            end
            if (b_inst_valid || b_data_valid) begin
                check("b_valid_excl", b_inst_valid && b_data_valid, 0);
                if (rsp_b.size() == 0) check("b_rsp_unexp", 1, 0);
                else begin
                    rb = rsp_b.pop_front();
                    check("b_owner", b_data_valid, rb.owner);
                    if (rb.chk_rd) check("b_rdata", rb.owner ? b_data_rdata : b_inst_rdata, rb.rdata);
                end
            end
        end
    end

    task automatic drive(input bit b, input bit dat, input logic req, input logic wr,
                         input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wd);
        if (!b) begin
            if (dat) begin
                a_data_req = req; a_data_wr = wr; a_data_be = be; a_data_addr = addr; a_data_wdata = wd;
            end else begin
                a_inst_req = req; a_inst_addr = addr;
            end
        end else begin
            if (dat) begin
                b_data_req = req; b_data_wr = wr; b_data_be = be; b_data_addr = addr; b_data_wdata = wd;
            end else begin
                b_inst_req = req; b_inst_addr = addr;
            end
        end
    endtask

    task automatic xact(input bit b, input bit dat, input logic wr, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_addr, input logic [3:0] exp_wen,
                        input logic [31:0] exp_rd, input bit chk_rd, input string tag);
        iss_t ie;
        rsp_t re;
        int   c0;
        int   n;
        logic v;
        ie.addr  = exp_addr;
        ie.wen   = exp_wen;
        ie.wdata = dat ? wd : 32'h0;
        re.owner  = dat;
        re.rdata  = exp_rd;
        re.chk_rd = chk_rd;
        if (b) begin iss_b.push_back(ie); rsp_b.push_back(re); end
        else   begin iss_a.push_back(ie); rsp_a.push_back(re); end
        @(posedge clk); #1;
        c0 = cyc;
        drive(b, dat, 1'b1, wr, be, addr, wd);
        n = 0;
        v = 1'b0;
        while (!v && n < 60) begin
            @(negedge clk);
            n++;
            v = b ? (dat ? b_data_valid : b_inst_valid) : (dat ? a_data_valid : a_inst_valid);
        end
        check({tag, "_lat"}, cyc - c0, b ? L3 + 2 : L1 + 2);
        check({tag, "_iss"}, (b ? last_b : last_a) - c0, 1);
        @(posedge clk); #1;
        drive(b, dat, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    task automatic chk_zero_a(input string tag);
        check({tag, "_mem_en"}, a_mem_en, 0);
        check({tag, "_mem_wen"}, a_mem_wen, 0);
        check({tag, "_mem_addr"}, a_mem_addr, 0);
        check({tag, "_mem_wdata"}, a_mem_wdata, 0);
        check({tag, "_ivalid"}, a_inst_valid, 0);
        check({tag, "_dvalid"}, a_data_valid, 0);
        check({tag, "_irdata"}, a_inst_rdata, 0);
        check({tag, "_drdata"}, a_data_rdata, 0);
    endtask

    initial begin
        iss_t ti;
        int   c0;
        int   ngr;
        int   last;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0); drive(0, 1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0); drive(1, 1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero_a("rst");
        check("rst_b_mem_en", b_mem_en, 0);
        check("rst_b_ivalid", b_inst_valid, 0);
        rst = 1'b0;

        xact(0, 1, 0, 4'h0, 32'h0000_0013, 32'h0, 32'h0000_0010, 4'h0, 32'hDEAD_BEEF, 1, "ld13");
        xact(0, 0, 0, 4'h0, 32'h0000_0040, 32'h0, 32'h0000_0040, 4'h0, 32'hC0DE_0010, 1, "if40");
        check("hold_drdata", a_data_rdata, 32'hDEAD_BEEF);
        xact(0, 1, 1, 4'b0011, 32'h0000_0020, 32'h1234_5678, 32'h0000_0020, 4'b0011, 32'h0, 0, "st20");
        check("st20_mem", mem_a[8], 32'hC0DE_5678);
        xact(0, 1, 1, 4'b0000, 32'h0000_0031, 32'hFFFF_FFFF, 32'h0000_0030, 4'b0000, 32'h0, 0, "st0be");
        check("st0be_mem", mem_a[12], 32'hC0DE_000C);
        check("hold_irdata", a_inst_rdata, 32'hC0DE_0010);

        xact(1, 0, 0, 4'h0, 32'h0000_0400, 32'h0, 32'h0000_0400, 4'h0, 32'hB0B0_0100, 1, "b_if400");
        xact(1, 1, 0, 4'h0, 32'h0000_000A, 32'h0, 32'h0000_0008, 4'h0, 32'hB0B0_0002, 1, "b_ld08");

        // Abandon a load during WAIT: issue is seen, no response ever arrives.
        ti.addr = 32'h10; ti.wen = 4'h0; ti.wdata = 32'h0;
        iss_a.push_back(ti);
        @(posedge clk); #1;
        c0 = cyc;
        drive(0, 1, 1, 0, 0, 32'h0000_0013, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        drive(0, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk_zero_a("rstmid");
        check("rstmid_iss", last_a - c0, 1);
        rst = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("rstmid_noval", a_data_valid, 0);
        end
        xact(0, 1, 0, 4'h0, 32'h0000_0013, 32'h0, 32'h0000_0010, 4'h0, 32'hDEAD_BEEF, 1, "ld_after_rst");

        // Both requesters held: four data grants then one forced fetch, repeating.
        for (int k = 0; k < 10; k++) begin
            iss_t ie;
            rsp_t re;
            ie.wen = 4'h0; ie.wdata = 32'h0; re.chk_rd = 1'b1;
            if (k % 5 == 4) begin
                ie.addr = 32'h200; re.owner = 1'b0; re.rdata = 32'hC0DE_0080;
            end else begin
                ie.addr = 32'h104; re.owner = 1'b1; re.rdata = 32'hC0DE_0041;
            end
            iss_a.push_back(ie);
            rsp_a.push_back(re);
        end
        @(posedge clk); #1;
        drive(0, 1, 1, 0, 0, 32'h104, 0);
        drive(0, 0, 1, 0, 0, 32'h200, 0);
        ngr  = 0;
        last = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_mem_en) begin
                if (ngr > 0) check("gr_gap", cyc - last, L1 + 3);
                last = cyc;
                ngr++;
            end
        end
        check("gr_cnt", ngr, 10);
        @(posedge clk); #1;
        drive(0, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (6) @(negedge clk);

        check("a_iss_left", iss_a.size(), 0);
        check("a_rsp_left", rsp_a.size(), 0);
        check("b_iss_left", iss_b.size(), 0);
        check("b_rsp_left", rsp_b.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
